comma_align_ctrl: RTL and testbench

Receive-side alignment controller that sits between the deserializer and the `synchronization` block of the PCS receive path. It takes unaligned 10-bit words, searches all ten bit offsets for a comma, confirms the offset, and then feeds aligned code-groups to `synchronization` on `pudi`/`indicate`. It also watches `code_sync_status` and re-hunts for alignment when sync is lost.

---
 rtl/comma_align_ctrl.sv | 155 +++++++++++++++
 tb/tb_comma_align_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comma_align_ctrl.sv
// Comma search/confirm/lock controller feeding aligned code-groups to synchronization.
// Optional COMMA_ALIGN_STATS_EN adds a saturating realign_count port.
module comma_align_ctrl #(
    parameter int unsigned CG_WIDTH       = 10,
    parameter int unsigned CONFIRM_COMMAS = 3,
    parameter int unsigned CONFIRM_WINDOW = 64,
    parameter int unsigned LOSS_WORDS     = 8
) (
    input  logic                clk,
    input  logic                mr_main_reset,
    input  logic [CG_WIDTH-1:0] rx_raw,
    input  logic                rx_raw_valid,
    input  logic                code_sync_status,
    output logic [CG_WIDTH-1:0] pudi,
    output logic                indicate,
    output logic                aligned,
    output logic [3:0]          offset
`ifdef COMMA_ALIGN_STATS_EN
    ,
    output logic [15:0]         realign_count
`endif
);

    localparam int unsigned WIN_W  = $clog2(CONFIRM_WINDOW + 1);
    localparam int unsigned CC_W   = $clog2(CONFIRM_COMMAS + 1);
    localparam int unsigned LOSS_W = $clog2(LOSS_WORDS + 1);

    typedef enum logic [1:0] {
        HUNT,
        CONFIRM,
        LOCKED
    } state_t;

    state_t              state;
    logic [CG_WIDTH-1:0] prev;
    logic [WIN_W-1:0]    win_cnt;
    logic [CC_W-1:0]     comma_cnt;
    logic [LOSS_W-1:0]   loss_cnt;

    // The last raw bit never starts a candidate, so the window stops one bit short.
    logic [2*CG_WIDTH-2:0] window;
    logic [CG_WIDTH-1:0]   cand [CG_WIDTH];
    logic [CG_WIDTH-1:0]   comma_at;
    logic                  hunt_hit;
    logic [3:0]            hunt_off;
    logic [CG_WIDTH-1:0]   sel_word;
    logic                  sel_comma;
    logic [WIN_W-1:0]      win_nxt;
    logic [CC_W-1:0]       comma_nxt;
    logic [LOSS_W-1:0]     loss_nxt;

    assign window = {prev, rx_raw[CG_WIDTH-1:1]};

    for (genvar k = 0; k < CG_WIDTH; k++) begin : g_cand
        assign cand[k]     = window[2*CG_WIDTH-2-k -: CG_WIDTH];
        assign comma_at[k] = (cand[k][CG_WIDTH-1 -: 7] == 7'b0011111) ||
                             (cand[k][CG_WIDTH-1 -: 7] == 7'b1100000);
    end

    // Lowest offset holding a comma wins the hunt.
    always_comb begin
        hunt_hit = 1'b0;
        hunt_off = '0;
        for (int k = CG_WIDTH - 1; k >= 0; k--) begin
            if (comma_at[k]) begin
                hunt_hit = 1'b1;
                hunt_off = 4'(k);
            end
        end
    end

    assign sel_word  = cand[offset];
    assign sel_comma = comma_at[offset];
    assign win_nxt   = win_cnt + WIN_W'(1);
    assign comma_nxt = comma_cnt + CC_W'(sel_comma);
    assign loss_nxt  = loss_cnt + LOSS_W'(1);

    always_ff @(posedge clk) begin
        if (mr_main_reset) begin
            state     <= HUNT;
            prev      <= '0;
            pudi      <= '0;
            indicate  <= 1'b0;
            aligned   <= 1'b0;
            offset    <= '0;
            win_cnt   <= '0;
            comma_cnt <= '0;
            loss_cnt  <= '0;
`ifdef COMMA_ALIGN_STATS_EN
            realign_count <= '0;
`endif
        end else begin
            indicate <= 1'b0;
            if (rx_raw_valid) begin
                prev <= rx_raw;
                unique case (state)
                    HUNT: begin
                        if (hunt_hit) begin
                            state     <= CONFIRM;
                            offset    <= hunt_off;
                            comma_cnt <= CC_W'(1);
                            win_cnt   <= '0;
                            loss_cnt  <= '0;
                        end
                    end
                    CONFIRM: begin
                        pudi     <= sel_word;
                        indicate <= 1'b1;
                        // Reaching the comma target takes priority over window expiry.
                        if (comma_nxt >= CC_W'(CONFIRM_COMMAS)) begin
                            state     <= LOCKED;
                            aligned   <= 1'b1;
                            win_cnt   <= '0;
                            comma_cnt <= '0;
                            loss_cnt  <= '0;
                        end else if (win_nxt >= WIN_W'(CONFIRM_WINDOW)) begin
                            state     <= HUNT;
                            win_cnt   <= '0;
                            comma_cnt <= '0;
                            loss_cnt  <= '0;
                        end else begin
                            win_cnt   <= win_nxt;
                            comma_cnt <= comma_nxt;
                        end
                    end
                    LOCKED: begin
                        pudi     <= sel_word;
                        indicate <= 1'b1;
                        if (code_sync_status) begin
                            loss_cnt <= '0;
                        end else if (loss_nxt >= LOSS_W'(LOSS_WORDS)) begin
                            state     <= HUNT;
                            aligned   <= 1'b0;
                            offset    <= '0;
                            win_cnt   <= '0;
                            comma_cnt <= '0;
                            loss_cnt  <= '0;
`ifdef COMMA_ALIGN_STATS_EN
                            if (realign_count != 16'hFFFF) begin
                                realign_count <= realign_count + 16'd1;
                            end
`endif
                        end else begin
                            loss_cnt <= loss_nxt;
                        end
                    end
                    default: begin
                        state <= HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_comma_align_ctrl.sv
// Randomized self-checking bench for comma_align_ctrl against a behavioural model.
module tb_comma_align_ctrl;

    logic       clk = 1'b0;
    logic       mr_main_reset;
    logic [9:0] rx_raw;
    logic       rx_raw_valid;
    logic       code_sync_status;
    logic [9:0] pudi;
    logic       indicate;
    logic       aligned;
    logic [3:0] offset;
`ifdef COMMA_ALIGN_STATS_EN
    logic [15:0] realign_count;
`endif

    always #5 clk = ~clk;

    comma_align_ctrl dut (
        .clk              (clk),
        .mr_main_reset    (mr_main_reset),
        .rx_raw           (rx_raw),
        .rx_raw_valid     (rx_raw_valid),
        .code_sync_status (code_sync_status),
        .pudi             (pudi),
        .indicate         (indicate),
        .aligned          (aligned),
        .offset           (offset)
`ifdef COMMA_ALIGN_STATS_EN
        ,
        .realign_count    (realign_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 searching, 1 confirming, 2 locked.
    int       m_phase;
    bit [9:0] m_prev;
    bit [9:0] m_pudi;
    bit       m_ind;
    bit       m_aln;
    int       m_off;
    int       m_commas;
    int       m_words;
    int       m_bad;
    int       m_realign;

    function automatic bit [9:0] cand_of(input bit [9:0] p, input bit [9:0] r, input int k);
        bit [19:0] w;
        w = {p, r} >> (10 - k);
        return w[9:0];
    endfunction

    function automatic bit is_comma(input bit [9:0] c);
        return (c[9:3] == 7'b0011111) || (c[9:3] == 7'b1100000);
    endfunction

    task automatic model_step(input bit rst, input bit [9:0] raw, input bit valid, input bit css);
        int lowest;
        bit [9:0] word;
        if (rst) begin
            m_phase = 0; m_prev = '0; m_pudi = '0; m_ind = 0; m_aln = 0;
            m_off = 0; m_commas = 0; m_words = 0; m_bad = 0; m_realign = 0;
            return;
        end
        m_ind = 0;
        if (!valid) return;
        lowest = -1;
        for (int k = 9; k >= 0; k--)
            if (is_comma(cand_of(m_prev, raw, k))) lowest = k;
        word = cand_of(m_prev, raw, m_off);
        if (m_phase == 0) begin
            if (lowest >= 0) begin
                m_phase = 1; m_off = lowest; m_commas = 1; m_words = 0;
            end
        end else if (m_phase == 1) begin
            m_pudi = word; m_ind = 1;
            m_words++;
            if (is_comma(word)) m_commas++;
            if (m_commas >= 3) begin
                m_phase = 2; m_aln = 1; m_bad = 0;
            end else if (m_words >= 64) begin
                m_phase = 0;
            end
        end else begin
            m_pudi = word; m_ind = 1;
            if (css) m_bad = 0;
            else begin
                m_bad++;
                if (m_bad >= 8) begin
                    m_phase = 0; m_aln = 0; m_off = 0;
                    if (m_realign < 65535) m_realign++;
                end
            end
        end
        m_prev = raw;
    endtask

    task automatic compare_all();
        check("pudi", 32'(pudi), 32'(m_pudi));
        check("indicate", 32'(indicate), 32'(m_ind));
        check("aligned", 32'(aligned), 32'(m_aln));
        check("offset", 32'(offset), 32'(m_off));
`ifdef COMMA_ALIGN_STATS_EN
        check("realign_count", 32'(realign_count), 32'(m_realign));
`endif
    endtask

    task automatic step(input bit rst, input bit [9:0] raw, input bit valid, input bit css);
        @(negedge clk);
        mr_main_reset    = rst;
        rx_raw           = raw;
        rx_raw_valid     = valid;
        code_sync_status = css;
        @(posedge clk);
        model_step(rst, raw, valid, css);
        #1;
        compare_all();
    endtask

    // Serial K28.5 / D16.2 stream, cut into raw words after a few leading junk bits.
    bit       bitq[$];
    int       pat_idx;
    bit [9:0] pat [4] = '{10'b0011111010, 10'b1001000101, 10'b1100000101, 10'b0110110101};

    task automatic stream_start(input int rot);
        bitq.delete();
        pat_idx = 0;
        for (int i = 0; i < rot; i++) bitq.push_back(bit'((i % 2) == 0));
    endtask

    function automatic bit [9:0] next_raw();
        bit [9:0] r;
        bit [9:0] w;
        while (bitq.size() < 10) begin
            w = pat[pat_idx % 4];
            pat_idx++;
            for (int b = 9; b >= 0; b--) bitq.push_back(w[b]);
        end
        for (int b = 9; b >= 0; b--) r[b] = bitq.pop_front();
        return r;
    endfunction

    initial begin
        int nv;
        bit v;
        bit css;
        int len;
        mr_main_reset = 1'b1; rx_raw = '0; rx_raw_valid = 1'b0; code_sync_status = 1'b1;

        // Reset with random raw words.
        for (int i = 0; i < 2; i++) step(1'b1, 10'($urandom), 1'($urandom), 1'($urandom));
        check("rst_pudi", 32'(pudi), 32'h0);
        check("rst_indicate", 32'(indicate), 32'h0);
        check("rst_aligned", 32'(aligned), 32'h0);
        check("rst_offset", 32'(offset), 32'h0);

        // Lock at offset 3, one valid word per cycle.
        stream_start(3);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, next_raw(), 1'b1, 1'b1);
            if (i == 1) check("lock_offset", 32'(offset), 32'd3);
            if (i == 4) check("lock_early", 32'(aligned), 32'd0);
        end
        check("lock_aligned", 32'(aligned), 32'd1);
        check("lock_pudi", 32'(pudi), 32'(10'b0011111010));

        // Loss of sync: 7 bad words tolerated, 8 force a re-hunt.
        for (int i = 0; i < 7; i++) step(1'b0, next_raw(), 1'b1, 1'b0);
        step(1'b0, next_raw(), 1'b1, 1'b1);
        check("loss_hold", 32'(aligned), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, next_raw(), 1'b1, 1'b0);
        check("loss_aligned", 32'(aligned), 32'd0);
        check("loss_offset", 32'(offset), 32'd0);
`ifdef COMMA_ALIGN_STATS_EN
        check("loss_realign", 32'(realign_count), 32'd1);
`endif
        step(1'b0, next_raw(), 1'b1, 1'b1);
        check("loss_indicate", 32'(indicate), 32'd0);

        // Confirm timeout: one comma at offset 7, then 64 comma-free words.
        step(1'b1, 10'd0, 1'b1, 1'b1);
        step(1'b0, 10'b0000000001, 1'b1, 1'b1);
        step(1'b0, 10'b1111000000, 1'b1, 1'b1);
        check("to_offset", 32'(offset), 32'd7);
        for (int i = 0; i < 64; i++) step(1'b0, 10'd0, 1'b1, 1'b1);
        check("to_last_ind", 32'(indicate), 32'd1);
        step(1'b0, 10'd0, 1'b1, 1'b1);
        check("to_indicate", 32'(indicate), 32'd0);
        check("to_aligned", 32'(aligned), 32'd0);

        // Valid gaps: lock point counted in valid words only.
        step(1'b1, 10'd0, 1'b0, 1'b1);
        stream_start(3);
        nv = 0;
        for (int c = 0; c < 14; c++) begin
            v = bit'(c % 2);
            step(1'b0, v ? next_raw() : 10'($urandom), v, 1'b1);
            if (v) nv++;
            if (!v) check("gap_indicate", 32'(indicate), 32'd0);
            if (v && nv == 5) check("gap_early", 32'(aligned), 32'd0);
            if (v && nv == 6) check("gap_lock", 32'(aligned), 32'd1);
        end

        // Reset mid-CONFIRM: comma count restarts from the next comma.
        step(1'b1, 10'd0, 1'b1, 1'b1);
        stream_start(3);
        for (int i = 0; i < 4; i++) step(1'b0, next_raw(), 1'b1, 1'b1);
        step(1'b1, 10'($urandom), 1'b1, 1'b1);
        check("mid_rst_aligned", 32'(aligned), 32'd0);
        stream_start(3);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, next_raw(), 1'b1, 1'b1);
            if (i == 3) check("mid_rst_hold", 32'(aligned), 32'd0);
        end
        check("mid_rst_lock", 32'(aligned), 32'd1);

        // Randomized phases: rotated streams, noise, gaps, sync loss, stray resets.
        for (int ph = 0; ph < 40; ph++) begin
            stream_start($urandom_range(0, 9));
            len = $urandom_range(20, 120);
            for (int i = 0; i < len; i++) begin
                v   = ($urandom_range(0, 3) != 0);
                css = ((ph % 3) == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) != 0);
                step($urandom_range(0, 299) == 0,
                     (v && (ph % 4) != 3) ? next_raw() : 10'($urandom), v, css);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
